// File: rtl/x7_scan_rx_if.sv
// Seven-segment scan bus as seen by the readback decoder: anode/segment lines in,
// reassembled bytes and status out.
interface x7_scan_rx_if;
    logic [3:0] an;
    logic [7:0] atog;
    logic [7:0] xq;
    logic [7:0] xh;
    logic       frame_valid;
    logic       err;
    logic [3:0] dig_seen;

    modport master (
        output an, atog,
        input  xq, xh, frame_valid, err, dig_seen
    );

    modport slave (
        input  an, atog,
        output xq, xh, frame_valid, err, dig_seen
    );
endinterface

// File: rtl/x7_scan_rx.sv
// Seven-segment scan decoder: waits for each anode/segment pattern to settle,
// decodes the digit and reassembles the xq/xh byte pair once all four slots are seen.
module x7_scan_rx #(
    parameter int unsigned SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    x7_scan_rx_if.slave  bus
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SLOTS  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SHD_W  = SLOTS * NIB_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             state_q,    state_d;
    logic [SLOTS-1:0]   an_r_q,     an_r_d;
    logic [BYTE_W-1:0]  atog_r_q,   atog_r_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [SHD_W-1:0]   shadow_q,   shadow_d;
    logic [SLOTS-1:0]   seen_q,     seen_d;
    logic [BYTE_W-1:0]  xq_q,       xq_d;
    logic [BYTE_W-1:0]  xh_q,       xh_d;
    logic               fv_q,       fv_d;
    logic               err_q,      err_d;

    logic               change;
    logic               sample;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NIB_W:0]     dec;
    logic [SLOTS-1:0]   seen_new;

    // Segment code to {valid, digit}; anything outside the table is rejected.
    function automatic logic [NIB_W:0] seg_decode(input logic [6:0] seg);
        logic [NIB_W:0] r;
        unique case (seg)
            7'h7E:   r = {1'b1, 4'd0};
            7'h30:   r = {1'b1, 4'd1};
            7'h6D:   r = {1'b1, 4'd2};
            7'h79:   r = {1'b1, 4'd3};
            7'h33:   r = {1'b1, 4'd4};
            7'h5B:   r = {1'b1, 4'd5};
            7'h5F:   r = {1'b1, 4'd6};
            7'h70:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h7B:   r = {1'b1, 4'd9};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        an_r_d   = bus.an;
        atog_r_d = bus.atog;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        seen_d   = seen_q;
        xq_d     = xq_q;
        xh_d     = xh_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        sample   = 1'b0;
        seen_new = seen_q;

        // A change is seen on the same edge that loads the new pattern into the input register.
        change  = ({bus.an, bus.atog} != {an_r_q, atog_r_q});
        cnt_inc = (cnt_q >= CNT_W'(SETTLE)) ? cnt_q : cnt_q + CNT_W'(1);
        dec     = seg_decode(atog_r_q[6:0]);

        if (change) begin
            cnt_d   = '0;
            state_d = $onehot(bus.an) ? S_WAIT : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: cnt_d = '0;
                S_WAIT: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(SETTLE - 1)) begin
                        state_d = S_HOLD;
                        sample  = 1'b1;
                    end
                end
                S_HOLD: cnt_d = cnt_inc;
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // The decimal point must be lit exactly on slot 2.
        if (sample) begin
            if (dec[NIB_W] && (atog_r_q[7] == an_r_q[2])) begin
                for (int i = 0; i < int'(SLOTS); i++) begin
                    if (an_r_q[i]) shadow_d[i*NIB_W +: NIB_W] = dec[NIB_W-1:0];
                end
                seen_new = seen_q | an_r_q;
                if (&seen_new) begin
                    xq_d   = shadow_d[SHD_W-1:BYTE_W];
                    xh_d   = shadow_d[BYTE_W-1:0];
                    fv_d   = 1'b1;
                    seen_d = '0;
                end else begin
                    seen_d = seen_new;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            an_r_q   <= '0;
            atog_r_q <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            seen_q   <= '0;
            xq_q     <= '0;
            xh_q     <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            an_r_q   <= an_r_d;
            atog_r_q <= atog_r_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            xq_q     <= xq_d;
            xh_q     <= xh_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    assign bus.xq          = xq_q;
    assign bus.xh          = xh_q;
    assign bus.frame_valid = fv_q;
    assign bus.err         = err_q;
    assign bus.dig_seen    = seen_q;

endmodule

// File: tb/tb_x7_scan_rx.sv
// Scoreboard bench for x7_scan_rx: directed scan patterns push expected frame/err
// events with their due cycle; a monitor pops and compares each event the DUT emits.
module tb_x7_scan_rx;

    localparam int unsigned SETTLE = 4;
    localparam logic [1:0]  K_NONE  = 2'd0;
    localparam logic [1:0]  K_FRAME = 2'd1;
    localparam logic [1:0]  K_ERR   = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        int unsigned cyc;
        logic [7:0]  xq;
        logic [7:0]  xh;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    x7_scan_rx_if bus_if ();

    x7_scan_rx #(.SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a pattern at the current negedge and hold it for 'hold' rising edges.
    task automatic present(input logic [3:0] an, input logic [7:0] atog, input int hold,
                           input logic [1:0] kind, input logic [7:0] exq, input logic [7:0] exh);
        bus_if.an   = an;
        bus_if.atog = atog;
        if (kind != K_NONE) sb_q.push_back('{kind: kind, cyc: cyc + SETTLE, xq: exq, xh: exh});
        repeat (hold) @(negedge clk);
    endtask

    task automatic idle(input int n);
        present(4'b0000, 8'h00, n, K_NONE, 8'h00, 8'h00);
    endtask

    // Monitor: every emitted pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.frame_valid || bus_if.err) begin
            check("fv_err_exclusive", {31'b0, bus_if.frame_valid & bus_if.err}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: fv=%0b err=%0b at cycle %0d, none expected",
                         bus_if.frame_valid, bus_if.err, cyc);
            end else begin
                e = sb_q.pop_front();
                check("event_kind", {30'b0, bus_if.err, bus_if.frame_valid}, {30'b0, e.kind});
                check("event_cycle", cyc, e.cyc);
                if (e.kind == K_FRAME) begin
                    check("frame_xq", {24'b0, bus_if.xq}, {24'b0, e.xq});
                    check("frame_xh", {24'b0, bus_if.xh}, {24'b0, e.xh});
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus_if.an   = 4'b0000;
        bus_if.atog = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_xq", {24'b0, bus_if.xq}, 32'h0);
        check("rst_xh", {24'b0, bus_if.xh}, 32'h0);
        check("rst_fv", {31'b0, bus_if.frame_valid}, 32'h0);
        check("rst_err", {31'b0, bus_if.err}, 32'h0);
        check("rst_dig_seen", {28'b0, bus_if.dig_seen}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Basic frame: xh=21, xq=93 in natural slot order.
        present(4'b0001, 8'h30, 8, K_NONE, 8'h00, 8'h00);
        present(4'b0010, 8'h6D, 8, K_NONE, 8'h00, 8'h00);
        check("t1_dig_seen_partial", {28'b0, bus_if.dig_seen}, 32'h3);
        present(4'b0100, 8'hF9, 8, K_NONE, 8'h00, 8'h00);
        present(4'b1000, 8'h7B, 8, K_FRAME, 8'h93, 8'h21);
        idle(3);
        check("t1_xh", {24'b0, bus_if.xh}, 32'h21);
        check("t1_xq", {24'b0, bus_if.xq}, 32'h93);
        check("t1_dig_seen_clear", {28'b0, bus_if.dig_seen}, 32'h0);

        // Glitches: each slot held one edge short of settling.
        present(4'b0001, 8'h30, 3, K_NONE, 8'h00, 8'h00);
        present(4'b0010, 8'h6D, 3, K_NONE, 8'h00, 8'h00);
        present(4'b0100, 8'hF9, 3, K_NONE, 8'h00, 8'h00);
        present(4'b1000, 8'h7B, 3, K_NONE, 8'h00, 8'h00);
        idle(3);
        check("t2_dig_seen", {28'b0, bus_if.dig_seen}, 32'h0);

        // Undecodable segment code.
        present(4'b0001, 8'h00, 8, K_ERR, 8'h00, 8'h00);
        check("t3_dig_seen", {28'b0, bus_if.dig_seen}, 32'h0);

        // Decimal point mismatches on slot 2 and slot 1.
        present(4'b0100, 8'h79, 8, K_ERR, 8'h00, 8'h00);
        present(4'b0010, 8'hB0, 8, K_ERR, 8'h00, 8'h00);
        check("t4_dig_seen", {28'b0, bus_if.dig_seen}, 32'h0);

        // Multi-hot anodes are ignored silently.
        present(4'b0011, 8'h30, 8, K_NONE, 8'h00, 8'h00);
        idle(2);
        check("t4b_dig_seen", {28'b0, bus_if.dig_seen}, 32'h0);

        // Out of order with slot 1 overwritten: xq=48, xh=76.
        present(4'b1000, 8'h33, 8, K_NONE, 8'h00, 8'h00);
        check("t5_dig_seen_s3", {28'b0, bus_if.dig_seen}, 32'h8);
        present(4'b0010, 8'h5B, 8, K_NONE, 8'h00, 8'h00);
        check("t5_dig_seen_s1", {28'b0, bus_if.dig_seen}, 32'hA);
        present(4'b0010, 8'h70, 8, K_NONE, 8'h00, 8'h00);
        check("t5_dig_seen_s1b", {28'b0, bus_if.dig_seen}, 32'hA);
        present(4'b0001, 8'h5F, 8, K_NONE, 8'h00, 8'h00);
        present(4'b0100, 8'hFF, 8, K_FRAME, 8'h48, 8'h76);
        idle(2);
        check("t5_xh_hi", {28'b0, bus_if.xh[7:4]}, 32'h7);
        check("t5_dig_seen_clear", {28'b0, bus_if.dig_seen}, 32'h0);

        // Mid-frame reset discards partial digits.
        present(4'b0001, 8'h30, 8, K_NONE, 8'h00, 8'h00);
        present(4'b0010, 8'h6D, 8, K_NONE, 8'h00, 8'h00);
        present(4'b0100, 8'hF9, 8, K_NONE, 8'h00, 8'h00);
        idle(2);
        check("t6_dig_seen_pre", {28'b0, bus_if.dig_seen}, 32'h7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_dig_seen", {28'b0, bus_if.dig_seen}, 32'h0);
        present(4'b1000, 8'h5B, 8, K_NONE, 8'h00, 8'h00);
        idle(2);
        check("t6_dig_seen", {28'b0, bus_if.dig_seen}, 32'h8);
        check("t6_xq", {24'b0, bus_if.xq}, 32'h0);
        check("t6_xh", {24'b0, bus_if.xh}, 32'h0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
